// File: rtl/logic_unit_pipe_if.sv
// Valid/ready bus of the pipelined bitwise logic unit: beat input side and
// registered result output side.
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_acc;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_red_and;
  logic             out_red_or;
  logic             out_red_xor;
  logic [CNT_W-1:0] out_beats;

  // Producer of beats / consumer of results.
  modport master (
    output in_valid, in_a, in_b, in_op, in_acc, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_red_and, out_red_or,
           out_red_xor, out_beats
  );

  // The logic unit itself.
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_acc, in_last, out_ready,
    output in_ready, out_valid, out_data, out_red_and, out_red_or,
           out_red_xor, out_beats
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit. Single beats produce a result directly;
// an accumulate burst folds each beat's B operand into an internal
// accumulator and emits one result on the last beat. The result register
// carries reduction flags and a saturating beat count.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  logic_unit_pipe_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_NOT  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  function automatic logic [WIDTH-1:0] apply_op(
    input op_e              op,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_NOT:  r = ~x;
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      OP_XOR:  r = x ^ y;
      OP_XNOR: r = ~(x ^ y);
      default: r = x;
    endcase
    return r;
  endfunction

  state_e           state, state_next;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             red_and_q, red_or_q, red_xor_q;
  logic [CNT_W-1:0] out_beats_q;

  logic             in_ready;
  logic             accept;
  logic             load_out;
  logic             load_acc;
  logic [WIDTH-1:0] operand_x;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] beats_next;

  // Input is accepted whenever the output register is empty or draining.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: enter ACCUM on a non-final accumulate beat, leave on the last.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && bus.in_acc && !bus.in_last) state_next = ACCUM;
      ACCUM:   if (accept && bus.in_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/datapath control: operand select, op result, load strobes, beat count.
  always_comb begin
    operand_x  = bus.in_a;
    load_out   = 1'b0;
    load_acc   = 1'b0;
    beats_next = CNT_W'(1);
    case (state)
      IDLE: begin
        load_out = accept && (!bus.in_acc || bus.in_last);
        load_acc = accept && bus.in_acc && !bus.in_last;
      end
      ACCUM: begin
        operand_x  = acc;
        load_out   = accept && bus.in_last;
        load_acc   = accept && !bus.in_last;
        beats_next = (cnt == '1) ? cnt : cnt + CNT_W'(1);
      end
      default: ;
    endcase
    result = apply_op(op_e'(bus.in_op), operand_x, bus.in_b);
  end

  // Accumulator and running beat count for an open burst.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (load_acc) begin
      acc <= result;
      cnt <= beats_next;
    end
  end

  // Result register: load on a result-producing beat, otherwise retire on out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      red_and_q   <= 1'b0;
      red_or_q    <= 1'b0;
      red_xor_q   <= 1'b0;
      out_beats_q <= '0;
    end else if (load_out) begin
      out_valid_q <= 1'b1;
      out_data_q  <= result;
      red_and_q   <= &result;
      red_or_q    <= |result;
      red_xor_q   <= ^result;
      out_beats_q <= beats_next;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_red_and = red_and_q;
  assign bus.out_red_or  = red_or_q;
  assign bus.out_red_xor = red_xor_q;
  assign bus.out_beats   = out_beats_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (WIDTH=8, CNT_W=8).
module tb_logic_unit_pipe;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic_unit_pipe_if #(.WIDTH(8), .CNT_W(8)) bus ();

  logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // {valid, data, red_and, red_or, red_xor, beats}
  logic [19:0] obs;
  assign obs = {bus.out_valid, bus.out_data, bus.out_red_and, bus.out_red_or,
                bus.out_red_xor, bus.out_beats};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic acc, input logic last);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_acc   = acc;
    bus.in_last  = last;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b000, 8'hFF, 8'hFF, 1'b0, 1'b1);
    step();
    step();
    total++;
    if (obs !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=%h", obs, 20'h0);
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
    step();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_accept got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_op_sweep();
    logic [7:0] exp_d [8];
    logic [7:0] d;
    exp_d = '{8'hC0, 8'hFC, 8'h0F, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'hF0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 8'hF0, 8'hCC, 1'b0, 1'b1);
      step();
      d = exp_d[i];
      total++;
      if (obs !== {1'b1, d, &d, |d, ^d, 8'd1}) begin
        bad++;
        $display("FAIL op_sweep[%0d] got=%h want=%h", i, obs, {1'b1, d, &d, |d, ^d, 8'd1});
      end
      if (i == 5) begin
        total++;
        if ({bus.out_red_and, bus.out_red_or, bus.out_red_xor} !== 3'b010) begin
          bad++;
          $display("FAIL flags_3C got=%b%b%b want=010", bus.out_red_and,
                   bus.out_red_or, bus.out_red_xor);
        end
      end
    end
    bus.in_valid = 1'b0;
    step();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL op_sweep_retire got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_xor_burst();
    drive(1'b1, 3'b101, 8'h01, 8'h02, 1'b1, 1'b0);
    step();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL xor_burst_beat1 got=%b want=0", bus.out_valid);
    end
    drive(1'b1, 3'b101, 8'hFF, 8'h04, 1'b1, 1'b0);
    step();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL xor_burst_beat2 got=%b want=0", bus.out_valid);
    end
    drive(1'b1, 3'b101, 8'hAA, 8'h08, 1'b0, 1'b1);
    step();
    total++;
    if (obs !== {1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 8'd3}) begin
      bad++;
      $display("FAIL xor_burst_result got=%h want=%h", obs, {1'b1, 8'h0F, 3'b010, 8'd3});
    end
    bus.in_valid = 1'b0;
    step();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL xor_burst_single got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_mixed_burst();
    drive(1'b1, 3'b001, 8'h00, 8'h0F, 1'b1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    drive(1'b1, 3'b000, 8'h55, 8'h3C, 1'b0, 1'b0);
    step();
    drive(1'b1, 3'b010, 8'h55, 8'h00, 1'b0, 1'b1);
    step();
    total++;
    if (obs !== {1'b1, 8'hF3, 1'b0, 1'b1, 1'b0, 8'd3}) begin
      bad++;
      $display("FAIL mixed_burst got=%h want=%h", obs, {1'b1, 8'hF3, 3'b010, 8'd3});
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b000, 8'hFF, 8'h0F, 1'b0, 1'b1);
    step();
    drive(1'b1, 3'b101, 8'hAA, 8'h55, 1'b0, 1'b1);
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_in_ready got=%b want=0", bus.in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({obs, bus.in_ready} !== {1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold[%0d] got=%h want=%h", i, {obs, bus.in_ready},
                 {1'b1, 8'h0F, 3'b010, 8'd1, 1'b0});
      end
    end
    bus.out_ready = 1'b1;
    step();
    total++;
    if (obs !== {1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 8'd1}) begin
      bad++;
      $display("FAIL bp_second got=%h want=%h", obs, {1'b1, 8'hFF, 3'b110, 8'd1});
    end
    bus.in_valid = 1'b0;
    step();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_no_dup got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_saturate();
    drive(1'b1, 3'b111, 8'h5A, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 299; i++) step();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL sat_midburst got=%b want=0", bus.out_valid);
    end
    bus.in_last = 1'b1;
    step();
    total++;
    if (obs !== {1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'hFF}) begin
      bad++;
      $display("FAIL sat_result got=%h want=%h", obs, {1'b1, 8'h5A, 3'b010, 8'hFF});
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_burst();
    drive(1'b1, 3'b001, 8'h0F, 8'hF0, 1'b1, 1'b0);
    step();
    step();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (obs !== 20'h0) begin
      bad++;
      $display("FAIL reset_mid_no_output got=%h want=%h", obs, 20'h0);
    end
    drive(1'b1, 3'b000, 8'hFF, 8'h55, 1'b0, 1'b1);
    step();
    total++;
    if (obs !== {1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'd1}) begin
      bad++;
      $display("FAIL reset_mid_single got=%h want=%h", obs, {1'b1, 8'h55, 3'b010, 8'd1});
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_op_sweep();
    test_xor_burst();
    test_mixed_burst();
    test_backpressure();
    test_saturate();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, registered bitwise logic unit: the multi-bit, pipelined successor to the single-bit gate primitives. Each accepted beat applies a selectable bitwise operation (AND/OR/NOT/NAND/NOR/XOR/XNOR/PASS) to two WIDTH-bit operands. Optionally, the unit folds a burst of beats into an internal accumulator. Results leave through a valid/ready output register with reduction flags and a beat count, for use as a datapath building block behind any valid/ready producer.

## Interface
- WIDTH, 8, operand/result width in bits (>= 1)
- CNT_W, 8, width of the beat counter (>= 2)

- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  unit can accept a beat this cycle
- in_a  input  WIDTH  operand A (ignored inside a burst)
- in_b  input  WIDTH  operand B
- in_op  input  3  operation select, per beat
- in_acc  input  1  start accumulate burst (sampled only in IDLE)
- in_last  input  1  final beat of burst / single beat
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  result
- out_red_and  output  1  &out_data
- out_red_or  output  1  |out_data
- out_red_xor  output  1  ^out_data
- out_beats  output  CNT_W  beats folded into this result, saturating at all-ones

## Operation
- Ops, f(x,y): 000 x&y; 001 x|y; 010 ~x (y ignored); 011 ~(x&y); 100 ~(x|y); 101 x^y; 110 ~(x^y); 111 x (pass).
- Accept = in_valid && in_ready at the clock edge. in_ready = !out_valid || out_ready, in every state.
- FSM, two states:
  - IDLE, accepted beat:
    - If in_acc=0 or in_last=1: out_data <= f(in_a,in_b); out_beats <= 1; out_valid <= 1; stay in IDLE.
    - If in_acc=1 and in_last=0: acc <= f(in_a,in_b); cnt <= 1; go to ACCUM; no output.
  - ACCUM, accepted beat: r = f(acc,in_b) using that beat's in_op. in_a and in_acc are ignored.
    - in_last=0: acc <= r; cnt <= cnt+1 (saturating); stay in ACCUM.
    - in_last=1: out_data <= r; out_beats <= cnt+1 (saturating); out_valid <= 1; go to IDLE.
- Reduction flags are registered together with out_data and always describe the current out_data.
- Output handshake: out_valid && out_ready retires the result. If no new result is loaded on the same edge, out_valid <= 0.
  - Accept and retire on the same edge: the new result replaces the old one, and out_valid stays 1.
- While out_valid && !out_ready: out_data, the flags and out_beats are held stable and in_ready=0. No beat is accepted, including intermediate ACCUM beats.
- acc and cnt are internal only. In IDLE they are don't-care.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_red_*=0, out_beats=0. in_ready=1 in the first cycle after reset.
- Reset has priority over every other event. Asserting it mid-burst discards the partial accumulation and does not produce an output.
- Latency: a result-producing beat accepted at edge N has out_valid=1 after edge N.
- Throughput: one beat per cycle while out_ready=1.
- A burst of K beats yields exactly one result, 1 cycle after its last beat is accepted.
- No combinational path from in_* to out_*. in_ready depends combinationally on out_valid and out_ready only.
- in_valid may be dropped between burst beats. ACCUM waits indefinitely.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_data=8'h00, flags=0, out_beats=0, nothing accepted. in_ready=1 after release.
- Op sweep (WIDTH=8, a=8'hF0, b=8'hCC, last=1, back-to-back, out_ready=1) -> results C0, FC, 0F, 3F, 03, 3C, C3, F0 on consecutive cycles, each 1 cycle after accept. For 3C: red_and=0, red_or=1, red_xor=0. out_beats=1 throughout.
- XOR burst: (acc=1, a=01, b=02, last=0), (b=04, last=0), (b=08, last=1) -> single result 8'h0F with out_beats=3. No out_valid during the first two beats.
- Mixed-op burst: (acc=1, op=OR, a=00, b=0F), (op=AND, b=3C), (op=NOT, last=1) -> result 8'hF3, out_beats=3.
- Backpressure: out_ready=0 with a result pending -> in_ready=0, out_data stable for 5 cycles, next beat held off. Raising out_ready -> both results delivered in order with no loss or duplication.
- Reset mid-burst after 2 accumulate beats -> no output. A following single beat AND FF,55 -> 8'h55, out_beats=1.
